// File: rtl/sram_ctrl_if.sv
// Request/response bundle between the load/store path (master) and
// the SRAM row controller (slave).
interface sram_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_we;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_we, rsp_rdata
  );
endinterface

// File: rtl/sram_ctrl.sv
// SRAM row controller: latches one word request, sequences word line and
// read/write strobes with fully registered array-side outputs, returns a response.
module sram_ctrl #(
  parameter  int ADDR_W    = 4,
  parameter  int DATA_W    = 32,
  parameter  int PULSE_CYC = 2,
  localparam int DEPTH     = 2**ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sram_ctrl_if.slave              bus,
  output logic [DEPTH-1:0]        wl,
  output logic [DATA_W-1:0]       arr_wdata,
  output logic                    read_pulse,
  output logic                    write_pulse,
  input  logic [DEPTH*DATA_W-1:0] arr_rdata
);

  localparam int CNT_W = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_PULSE  = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

  logic [2:0]        state_q,     state_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic              we_q,        we_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [DEPTH-1:0]  wl_q,        wl_d;
  logic [DATA_W-1:0] arr_wdata_q, arr_wdata_d;
  logic              rpulse_q,    rpulse_d;
  logic              wpulse_q,    wpulse_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_we_q,    rsp_we_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  assign bus.req_ready = (state_q == ST_IDLE) && rst_n;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_we    = rsp_we_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign wl            = wl_q;
  assign arr_wdata     = arr_wdata_q;
  assign read_pulse    = rpulse_q;
  assign write_pulse   = wpulse_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    wl_d        = wl_q;
    arr_wdata_d = arr_wdata_q;
    rpulse_d    = rpulse_q;
    wpulse_d    = wpulse_q;
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          we_d    = bus.req_we;
          wdata_d = bus.req_wdata;
          state_d = ST_DECODE;
        end
      end
      // Word line and bitline data are registered out of the latched request,
      // so they first appear one cycle after the accept edge.
      ST_DECODE: begin
        wl_d         = '0;
        wl_d[addr_q] = 1'b1;
        arr_wdata_d  = we_q ? wdata_q : '0;
        state_d      = ST_SETUP;
      end
      ST_SETUP: begin
        rpulse_d = !we_q;
        wpulse_d = we_q;
        cnt_d    = CNT_W'(PULSE_CYC);
        state_d  = ST_PULSE;
      end
      ST_PULSE: begin
        if (cnt_q == CNT_W'(1)) begin
          rpulse_d = 1'b0;
          wpulse_d = 1'b0;
          state_d  = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        wl_d        = '0;
        arr_wdata_d = '0;
        rsp_valid_d = 1'b1;
        rsp_we_d    = we_q;
        rsp_rdata_d = we_q ? '0 : arr_rdata[int'(addr_q)*DATA_W +: DATA_W];
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      wl_q        <= '0;
      arr_wdata_q <= '0;
      rpulse_q    <= 1'b0;
      wpulse_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      wl_q        <= wl_d;
      arr_wdata_q <= arr_wdata_d;
      rpulse_q    <= rpulse_d;
      wpulse_q    <= wpulse_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: directed vector table, reset corner cases,
// and randomized traffic against a word-array scoreboard.
module tb_sram_ctrl;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int PC = 2;
  localparam int DEPTH = 2**AW;

  logic clk, rst_n;
  logic [DEPTH-1:0]    wl;
  logic [DW-1:0]       arr_wdata;
  logic                read_pulse, write_pulse;
  logic [DEPTH*DW-1:0] arr_rdata;

  int checks = 0;
  int errors = 0;

  sram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .PULSE_CYC(PC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .wl(wl), .arr_wdata(arr_wdata),
    .read_pulse(read_pulse), .write_pulse(write_pulse), .arr_rdata(arr_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Row array: each row latches datain on a write strobe while its word line is up.
  logic [DW-1:0] rows [DEPTH];
  always @(posedge clk)
    for (int i = 0; i < DEPTH; i++)
      if (write_pulse && wl[i]) rows[i] <= arr_wdata;
  always_comb begin
    arr_rdata = '0;
    for (int i = 0; i < DEPTH; i++) arr_rdata[i*DW +: DW] = rows[i];
  end

  // Scoreboard: what every word should contain after the accepted writes.
  logic [DW-1:0] ref_mem [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((read_pulse && write_pulse) ||
          ((read_pulse || write_pulse) && wl == '0) ||
          ((wl & (wl - 1'b1)) != '0) ||
          ((bus.req_ready || bus.rsp_valid) && wl != '0)) begin
        errors++;
        $display("FAIL invariant wl=%h rp=%b wp=%b ready=%b rsp_valid=%b",
                 wl, read_pulse, write_pulse, bus.req_ready, bus.rsp_valid);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_bound", 32'(n < 50), 32'd1);
  endtask

  task automatic run_txn(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int stall, input logic [DW-1:0] exp_rd);
    int k, wl_cyc, rp_cyc, wp_cyc;
    logic [DEPTH-1:0] wl_seen;
    bit wd_ok;
    logic [DW-1:0] held;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wd;
    bus.rsp_ready = 1'b0;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = AW'($urandom);
    bus.req_wdata = $urandom;
    k = 0; wl_cyc = 0; rp_cyc = 0; wp_cyc = 0; wl_seen = '0; wd_ok = 1'b1;
    while (!bus.rsp_valid && k < 40) begin
      if (wl != '0) begin wl_cyc++; wl_seen |= wl; end
      if (read_pulse) rp_cyc++;
      if (write_pulse) begin
        wp_cyc++;
        if (arr_wdata !== wd) wd_ok = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(PC + 3));
    chk("wl_cycles", 32'(wl_cyc), 32'(PC + 2));
    chk("wl_onehot", 32'(wl_seen), 32'(1) << addr);
    chk("read_pulse_cycles", 32'(rp_cyc), we ? 32'd0 : 32'(PC));
    chk("write_pulse_cycles", 32'(wp_cyc), we ? 32'(PC) : 32'd0);
    chk("arr_wdata", 32'(wd_ok), 32'd1);
    chk("rsp_we", 32'(bus.rsp_we), 32'(we));
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    held = bus.rsp_rdata;
    bus.req_valid = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_stable", {29'd0, bus.rsp_valid, bus.req_ready, 1'(bus.rsp_rdata == held)},
          32'b101);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_release", {30'd0, bus.rsp_valid, bus.req_ready}, 32'b01);
    bus.rsp_ready = 1'b0;
  endtask

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            stall;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    vecs[0] = '{1'b1, 4'd3,  32'hDEADBEEF, 0,  32'h0};
    vecs[1] = '{1'b0, 4'd3,  32'h0,        0,  32'hDEADBEEF};
    vecs[2] = '{1'b1, 4'd0,  32'hA5A5A5A5, 0,  32'h0};
    vecs[3] = '{1'b1, 4'd15, 32'h5A5A5A5A, 0,  32'h0};
    vecs[4] = '{1'b0, 4'd0,  32'h0,        0,  32'hA5A5A5A5};
    vecs[5] = '{1'b0, 4'd15, 32'h0,        1,  32'h5A5A5A5A};
    vecs[6] = '{1'b0, 4'd3,  32'h0,        10, 32'hDEADBEEF};
    vecs[7] = '{1'b1, 4'd15, 32'h00000000, 0,  32'h0};
    vecs[8] = '{1'b0, 4'd15, 32'h0,        0,  32'h00000000};
    vecs[9] = '{1'b0, 4'd0,  32'h0,        2,  32'hA5A5A5A5};

    rst_n = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'd5;
    bus.req_wdata = 32'h11111111; bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {26'd0, bus.req_ready, 1'(wl != '0), read_pulse, write_pulse,
                        bus.rsp_valid, bus.rsp_we}, 32'd0);
    chk("reset_rdata", bus.rsp_rdata, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_release", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b0;

    foreach (vecs[i]) begin
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].stall, vecs[i].exp_rd);
      if (vecs[i].we) ref_mem[vecs[i].addr] = vecs[i].wd;
    end

    // Reset while the write strobe is up: outputs drop without waiting for a clock.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'd7; bus.req_wdata = 32'h12345678;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!write_pulse && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pulse_seen", 32'(n < 20), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {28'd0, 1'(wl != '0), write_pulse, bus.req_ready, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_rsp_after_reset", 32'(bus.rsp_valid), 32'd0);
    end
    run_txn(1'b0, 4'd3, 32'h0, 0, 32'hDEADBEEF);

    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      run_txn(1'b1, AW'(i), d, 0, 32'h0);
      ref_mem[i] = d;
    end

    for (int t = 0; t < 1000; t++) begin
      we = 1'($urandom);
      a  = AW'($urandom);
      d  = $urandom;
      run_txn(we, a, d, int'($urandom_range(0, 3)), we ? 32'h0 : ref_mem[a]);
      if (we) ref_mem[a] = d;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
